// File: rtl/branch_predictor.sv
// Bimodal branch predictor: table of 2-bit saturating counters, trained from X.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor #(
    parameter int unsigned LINES        = 128,
    parameter logic [1:0]  COUNTER_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_guess,
    input  logic        is_br_guess,
    output logic        pred_taken,
    input  logic [31:0] pc_check,
    input  logic        is_br_check,
    input  logic        br_taken_check,
    output logic        mispredict,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
);

    localparam int unsigned IDX = $clog2(LINES);

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    ctr_e           table_q [LINES];
    ctr_e           ctr_q;
    ctr_e           ctr_d;
    logic [IDX-1:0] gi;
    logic [IDX-1:0] ti;
    logic           pred_q;
    logic [31:0]    br_count_q;
    logic [31:0]    br_count_d;
    logic [31:0]    mispred_count_q;
    logic [31:0]    mispred_count_d;
    logic           unused_pc;

`ifdef BP_GSHARE_EN
    logic [IDX-1:0] ghr_q;
    logic [IDX-1:0] ghr_d;
    logic [IDX-1:0] gi_q;

    // Train the entry that produced the prediction, not the one the PC maps to now.
    assign gi = pc_guess[IDX+1:2] ^ ghr_q;
    assign ti = gi_q;

    always_comb begin
        ghr_d = ghr_q;
        if (is_br_check) begin
            ghr_d = (ghr_q << 1) | IDX'(br_taken_check);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
            gi_q  <= '0;
        end else begin
            ghr_q <= ghr_d;
            gi_q  <= gi;
        end
    end

    assign unused_pc = ^{pc_guess[31:IDX+2], pc_guess[1:0], pc_check};
`else
    assign gi = pc_guess[IDX+1:2];
    assign ti = pc_check[IDX+1:2];

    assign unused_pc = ^{pc_guess[31:IDX+2], pc_guess[1:0],
                         pc_check[31:IDX+2], pc_check[1:0]};
`endif

    // Asynchronous read; a same-cycle write to gi is not bypassed.
    assign pred_taken = is_br_guess & table_q[gi][1];

    assign mispredict = is_br_check & (br_taken_check != pred_q);

    assign ctr_q = table_q[ti];

    always_comb begin
        ctr_d = ctr_q;
        unique case (ctr_q)
            SNT: ctr_d = br_taken_check ? WNT : SNT;
            WNT: ctr_d = br_taken_check ? WT  : SNT;
            WT:  ctr_d = br_taken_check ? ST  : WNT;
            ST:  ctr_d = br_taken_check ? ST  : WT;
        endcase
    end

    always_comb begin
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (is_br_check) begin
            br_count_d = br_count_q + 32'd1;
        end
        if (mispredict) begin
            mispred_count_d = mispred_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LINES; i++) begin
                table_q[i] <= ctr_e'(COUNTER_INIT);
            end
        end else if (is_br_check) begin
            table_q[ti] <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_q          <= 1'b0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            pred_q          <= pred_taken;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default bimodal build, LINES=128).
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pc_guess;
    logic        is_br_guess;
    logic        pred_taken;
    logic [31:0] pc_check;
    logic        is_br_check;
    logic        br_taken_check;
    logic        mispredict;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_vec;
    int n_err;

    branch_predictor #(
        .LINES(128),
        .COUNTER_INIT(2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc_guess(pc_guess),
        .is_br_guess(is_br_guess),
        .pred_taken(pred_taken),
        .pc_check(pc_check),
        .is_br_check(is_br_check),
        .br_taken_check(br_taken_check),
        .mispredict(mispredict),
        .br_count(br_count),
        .mispred_count(mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, then settle.
    task automatic cyc(input logic r, input logic gv, input logic [31:0] gpc,
                       input logic cv, input logic [31:0] cpc, input logic ct);
        @(negedge clk);
        rst            = r;
        is_br_guess    = gv;
        pc_guess       = gpc;
        is_br_check    = cv;
        pc_check       = cpc;
        br_taken_check = ct;
        #1;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst            = 1'b1;
        is_br_guess    = 1'b0;
        pc_guess       = '0;
        is_br_check    = 1'b0;
        pc_check       = '0;
        br_taken_check = 1'b0;

        // reset and first guess
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        chk("rst_br", br_count, 32'd0);
        chk("rst_mis", mispred_count, 32'd0);
        chk("rst_mp", {31'd0, mispredict}, 32'd0);

        // train 0x1000 taken three times
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1);
        chk("t1_mp", {31'd0, mispredict}, 32'd1);
        cyc(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
        chk("t1_pred", {31'd0, pred_taken}, 32'd1);
        chk("t1_br", br_count, 32'd1);
        chk("t1_mis", mispred_count, 32'd1);
        cyc(1'b0, 1'b1, 32'h1000, 1'b1, 32'h1000, 1'b1);
        chk("t2_mp", {31'd0, mispredict}, 32'd0);
        chk("t2_pred", {31'd0, pred_taken}, 32'd1);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1);
        chk("t3_mp", {31'd0, mispredict}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("t3_br", br_count, 32'd3);
        chk("t3_mis", mispred_count, 32'd1);

        // saturate down: 11 -> 10 -> 01 -> 00 -> 00 -> 00, then one more
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b0);
            chk("sat_mp", {31'd0, mispredict}, 32'd0);
        end
        cyc(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
        chk("sat_pred", {31'd0, pred_taken}, 32'd0);
        chk("sat_br", br_count, 32'd9);
        chk("sat_mis", mispred_count, 32'd1);
        // one taken step from 00 must still predict not-taken
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000, 1'b1);
        chk("sat_up_mp", {31'd0, mispredict}, 32'd1);
        cyc(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0);
        chk("sat_up_pred", {31'd0, pred_taken}, 32'd0);
        chk("sat_up_mis", mispred_count, 32'd2);

        // same-cycle guess and train at index 5
        cyc(1'b0, 1'b1, 32'h14, 1'b1, 32'h14, 1'b1);
        chk("same_pred0", {31'd0, pred_taken}, 32'd0);
        chk("same_mp", {31'd0, mispredict}, 32'd1);
        cyc(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0);
        chk("same_pred1", {31'd0, pred_taken}, 32'd1);
        chk("same_br", br_count, 32'd11);
        chk("same_mis", mispred_count, 32'd3);

        // aliasing: train index 0 (01 -> 11) via pc 0x0
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("alias_mp0", {31'd0, mispredict}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("alias_mp1", {31'd0, mispredict}, 32'd1);
        cyc(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
        chk("alias_pred", {31'd0, pred_taken}, 32'd1);
        cyc(1'b0, 1'b1, 32'h204, 1'b0, 32'h0, 1'b0);
        chk("alias_other", {31'd0, pred_taken}, 32'd0);
        chk("alias_br", br_count, 32'd13);
        chk("alias_mis", mispred_count, 32'd4);

        // reset wins over an in-flight taken branch
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("rst2_pred", {31'd0, pred_taken}, 32'd0);
        cyc(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst2_pred0", {31'd0, pred_taken}, 32'd0);
        chk("rst2_br", br_count, 32'd0);
        chk("rst2_mis", mispred_count, 32'd0);
        chk("rst2_mp", {31'd0, mispredict}, 32'd0);
        cyc(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 1'b0);
        chk("rst2_pred5", {31'd0, pred_taken}, 32'd0);
        // one taken step from COUNTER_INIT must flip the prediction
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        chk("rst2_mpx", {31'd0, mispredict}, 32'd1);
        cyc(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rst2_pred1", {31'd0, pred_taken}, 32'd1);
        chk("rst2_br1", br_count, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
